interrupt_sequencer: RTL and testbench
======================================

# interrupt_sequencer

Sequences machine-mode interrupt entry for the CSR unit and arbitrates its single update port between commit-stage traps, CSR-instruction writes and interrupts, guaranteeing that at most one of trap, interrupt or CSR write reaches the CSR unit per cycle. Sits between the commit stage / active list and the CSR unit. It samples the registered mstatus/mie/mip fields, stalls fetch, waits for the pipeline to drain, pulses the interrupt trigger with the resume PC, then issues the redirect to the trap vector.

## Interface
- DRAIN_TIMEOUT, 255: max DRAIN cycles before abort (macro-gated)
- HOLDOFF_CYCLES, 4: cycles the stall stays released after an abort (macro-gated)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- mstatusMIE, mieMTIE, mieMEIE, mipMTIP, mipMEIP  in  1 each  registered CSR fields
- extIntCode  in  ExternalInterruptCodePath  latched external code from CSR unit
- activeListEmpty  in  1  no uncommitted instructions in flight
- resumePC  in  PC_Path  PC where execution resumes after drain; valid while activeListEmpty
- excptReq / csrWriteReq  in  1 each  commit-stage trap request / CSR-instruction write request
- excptGrant / csrWriteGrant  out  1 each  forwarded as triggerExcpt / csrWE
- fetchStall  out  1  stop fetch and rename of new instructions
- triggerInterrupt  out  1  one-cycle pulse to CSR unit
- interruptCode  out  InterruptCodePath  MEI = 11, MTI = 7
- interruptRetAddr  out  PC_Path  captured resumePC
- redirect  out  1  one-cycle flush/redirect to the CSR unit's excptTargetAddr
- busy  out  1  state != IDLE

## Operation
- pending = mstatusMIE & ((mipMEIP & mieMEIE) | (mipMTIP & mieMTIE)); external wins over timer.
- States:
  - IDLE: if pending, go to DRAIN.
  - DRAIN: fetchStall=1.
    - excptReq: grant it, abort to IDLE. Exception has priority.
    - csrWriteReq: grant it, stay in DRAIN.
    - pending drops: abort to IDLE.
    - activeListEmpty & !excptReq & !csrWriteReq & pending: capture code and resumePC, go to TRIGGER.
  - TRIGGER: triggerInterrupt=1, fetchStall=1, both grants forced 0 (requesters hold); go to REDIRECT.
  - REDIRECT: redirect=1, fetchStall=1; go to IDLE. The CSR unit has cleared MIE by this cycle, so pending is 0 next cycle.
- Outside TRIGGER, excptGrant=excptReq and csrWriteGrant=csrWriteReq & !excptReq, combinationally.
- Invariant: excptGrant, csrWriteGrant and triggerInterrupt are mutually exclusive in every cycle.
- Code is captured at the DRAIN→TRIGGER edge and held stable through REDIRECT.
- Reset mid-sequence: immediate return to IDLE with all outputs 0; no partial trigger.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, interruptRetAddr 0.
- Minimum latency, pending to triggerInterrupt: 2 cycles (IDLE→DRAIN, DRAIN→TRIGGER with activeListEmpty already 1).
- Redirect follows triggerInterrupt by exactly 1 cycle. The total sequence is at least 4 cycles with busy=1 for at least 3.
- Grants are same-cycle combinational pass-through; the trigger/redirect outputs are registered state decodes.
- excptReq and activeListEmpty arriving in the same DRAIN cycle: the exception wins and the interrupt is re-evaluated from IDLE.

## Configuration
- RSD_INTERRUPT_DRAIN_TIMEOUT_EN defined:
  - An 8-bit drain counter runs in DRAIN. When it reaches DRAIN_TIMEOUT, the attempt aborts to a HOLDOFF state.
  - HOLDOFF: fetchStall=0 for HOLDOFF_CYCLES cycles, then IDLE.
  - Counter clears on DRAIN entry and saturates.
- Undefined: no counter and no HOLDOFF state; DRAIN waits indefinitely.

## Structure
- Shared package (CSR_UnitTypes):
  - InterruptSeqState enum
  - INTERRUPT_CODE_MEI / INTERRUPT_CODE_MTI constants
  - InterruptCodePath
  - default DRAIN_TIMEOUT / HOLDOFF_CYCLES constants
- Sub-module interrupt_priority_encoder: combinational pending and code selection. Everything else, including the FSM, capture registers and counters, stays in the top.

## Test plan
- mieMTIE=1, mstatusMIE=1, activeListEmpty=1, mipMTIP rises at cycle 0 → triggerInterrupt at cycle 2 with code 7; redirect at cycle 3; fetchStall cycles 1–3.
- MTIP and MEIP both pending → code 11; interruptRetAddr equals resumePC 0x1000 sampled at the DRAIN→TRIGGER edge.
- In DRAIN with activeListEmpty=0, excptReq=1 → excptGrant=1 the same cycle, back to IDLE, no triggerInterrupt; re-enters DRAIN next cycle while still pending.
- In DRAIN, csrWriteReq clears mstatusMIE → csrWriteGrant=1; the next cycle aborts to IDLE with no trigger.
- Async rst asserted during TRIGGER → all outputs 0 immediately, no redirect follows.
- With the macro defined and DRAIN_TIMEOUT=8, activeListEmpty held 0 → abort after 8 DRAIN cycles, fetchStall=0 for 4 cycles, then DRAIN again.

Source files
------------

// File: rtl/interrupt_sequencer_pkg.sv
// Shared CSR-unit types for the interrupt sequencer: state encoding, cause codes, path widths.
// HOLDOFF state exists only when RSD_INTERRUPT_DRAIN_TIMEOUT_EN is defined.
package CSR_UnitTypes;

    localparam int PC_WIDTH = 32;
    typedef logic [PC_WIDTH-1:0] PC_Path;

    typedef logic [3:0] InterruptCodePath;
    typedef logic [3:0] ExternalInterruptCodePath;

    localparam InterruptCodePath INTERRUPT_CODE_MEI = 4'd11;
    localparam InterruptCodePath INTERRUPT_CODE_MTI = 4'd7;

    localparam int DRAIN_TIMEOUT_DEFAULT  = 255;
    localparam int HOLDOFF_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        IS_IDLE,
        IS_DRAIN,
        IS_TRIGGER,
        IS_REDIRECT
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
        , IS_HOLDOFF
`endif
    } InterruptSeqState;

endpackage

// File: rtl/interrupt_sequencer_priority_encoder.sv
// Combinational machine-mode interrupt pending detection and cause selection.
// External interrupt outranks timer interrupt.
module interrupt_priority_encoder
    import CSR_UnitTypes::*;
(
    input  logic             mstatusMIE,
    input  logic             mieMTIE,
    input  logic             mieMEIE,
    input  logic             mipMTIP,
    input  logic             mipMEIP,
    output logic             pending,
    output InterruptCodePath code
);

    logic ext_active;
    logic tmr_active;

    assign ext_active = mipMEIP & mieMEIE;
    assign tmr_active = mipMTIP & mieMTIE;
    assign pending    = mstatusMIE & (ext_active | tmr_active);
    assign code       = ext_active ? INTERRUPT_CODE_MEI : INTERRUPT_CODE_MTI;

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences M-mode interrupt entry (drain, trigger, redirect) and arbitrates the CSR update port.
// Optional drain timeout with fetch holdoff is enabled by RSD_INTERRUPT_DRAIN_TIMEOUT_EN.
module interrupt_sequencer
    import CSR_UnitTypes::*;
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
#(
    parameter int DRAIN_TIMEOUT  = DRAIN_TIMEOUT_DEFAULT,
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT
)
`endif
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mstatusMIE,
    input  logic                     mieMTIE,
    input  logic                     mieMEIE,
    input  logic                     mipMTIP,
    input  logic                     mipMEIP,
    input  ExternalInterruptCodePath extIntCode,
    input  logic                     activeListEmpty,
    input  PC_Path                   resumePC,
    input  logic                     excptReq,
    input  logic                     csrWriteReq,
    output logic                     excptGrant,
    output logic                     csrWriteGrant,
    output logic                     fetchStall,
    output logic                     triggerInterrupt,
    output InterruptCodePath         interruptCode,
    output PC_Path                   interruptRetAddr,
    output logic                     redirect,
    output logic                     busy
);

    InterruptSeqState state_q, state_d;
    InterruptCodePath code_q;
    PC_Path           ret_addr_q;
    logic             capture;
    logic             pending;
    InterruptCodePath sel_code;
    logic             unused_ext_code;

    // The cause comes from mip/mie; the CSR unit's latched code is informational only.
    assign unused_ext_code = ^extIntCode;

    interrupt_priority_encoder u_prio (
        .mstatusMIE (mstatusMIE),
        .mieMTIE    (mieMTIE),
        .mieMEIE    (mieMEIE),
        .mipMTIP    (mipMTIP),
        .mipMEIP    (mipMEIP),
        .pending    (pending),
        .code       (sel_code)
    );

`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
        cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`endif
        unique case (state_q)
            IS_IDLE: begin
                if (pending) state_d = IS_DRAIN;
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            IS_DRAIN: begin
                if (excptReq) begin
                    state_d = IS_IDLE;
                end else if (csrWriteReq) begin
                    state_d = IS_DRAIN;
                end else if (!pending) begin
                    state_d = IS_IDLE;
                end else if (activeListEmpty) begin
                    state_d = IS_TRIGGER;
                    capture = 1'b1;
                end
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
                // Timeout only applies when nothing else resolved the attempt this cycle.
                if (state_d == IS_DRAIN && cnt_q >= 8'(DRAIN_TIMEOUT - 1)) begin
                    state_d = IS_HOLDOFF;
                    cnt_d   = '0;
                end
`endif
            end
            IS_TRIGGER:  state_d = IS_REDIRECT;
            IS_REDIRECT: state_d = IS_IDLE;
`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
            IS_HOLDOFF: begin
                if (cnt_q >= 8'(HOLDOFF_CYCLES - 1)) state_d = IS_IDLE;
            end
`endif
            default: state_d = IS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IS_IDLE;
            code_q     <= '0;
            ret_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                code_q     <= sel_code;
                ret_addr_q <= resumePC;
            end
        end
    end

`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    // Grants are withheld during TRIGGER so the CSR port sees only the interrupt.
    assign excptGrant       = !rst && (state_q != IS_TRIGGER) && excptReq;
    assign csrWriteGrant    = !rst && (state_q != IS_TRIGGER) && csrWriteReq && !excptReq;
    assign triggerInterrupt = (state_q == IS_TRIGGER);
    assign redirect         = (state_q == IS_REDIRECT);
    assign fetchStall       = (state_q == IS_DRAIN) || (state_q == IS_TRIGGER) ||
                              (state_q == IS_REDIRECT);
    assign busy             = (state_q != IS_IDLE);
    assign interruptCode    = code_q;
    assign interruptRetAddr = ret_addr_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer; timeout/holdoff steps build only with RSD_INTERRUPT_DRAIN_TIMEOUT_EN.
module tb_interrupt_sequencer;
    import CSR_UnitTypes::*;

    logic clk = 1'b0;
    logic rst;
    logic mstatusMIE, mieMTIE, mieMEIE, mipMTIP, mipMEIP;
    ExternalInterruptCodePath extIntCode;
    logic activeListEmpty;
    PC_Path resumePC;
    logic excptReq, csrWriteReq;
    logic excptGrant, csrWriteGrant, fetchStall, triggerInterrupt, redirect, busy;
    InterruptCodePath interruptCode;
    PC_Path interruptRetAddr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
    interrupt_sequencer #(.DRAIN_TIMEOUT(8), .HOLDOFF_CYCLES(4)) dut (
`else
    interrupt_sequencer dut (
`endif
        .clk              (clk),
        .rst              (rst),
        .mstatusMIE       (mstatusMIE),
        .mieMTIE          (mieMTIE),
        .mieMEIE          (mieMEIE),
        .mipMTIP          (mipMTIP),
        .mipMEIP          (mipMEIP),
        .extIntCode       (extIntCode),
        .activeListEmpty  (activeListEmpty),
        .resumePC         (resumePC),
        .excptReq         (excptReq),
        .csrWriteReq      (csrWriteReq),
        .excptGrant       (excptGrant),
        .csrWriteGrant    (csrWriteGrant),
        .fetchStall       (fetchStall),
        .triggerInterrupt (triggerInterrupt),
        .interruptCode    (interruptCode),
        .interruptRetAddr (interruptRetAddr),
        .redirect         (redirect),
        .busy             (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Status snapshot: {busy, fetchStall, triggerInterrupt, redirect}
    task automatic chk_st(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, busy, fetchStall, triggerInterrupt, redirect}, {28'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        {mstatusMIE, mieMTIE, mieMEIE, mipMTIP, mipMEIP} = '0;
        extIntCode = 4'd3;
        activeListEmpty = 1'b0;
        resumePC = '0;
        excptReq = 1'b0;
        csrWriteReq = 1'b0;
        step();
        step();
        chk_st("reset_status", 4'b0000);
        chk("reset_code", {28'd0, interruptCode}, 32'd0);
        chk("reset_retaddr", interruptRetAddr, 32'd0);
        chk("reset_grants", {30'd0, excptGrant, csrWriteGrant}, 32'd0);
        rst = 1'b0;
        step();

        // Timer interrupt, pipeline already empty: minimum latency path.
        mstatusMIE = 1'b1; mieMTIE = 1'b1; activeListEmpty = 1'b1;
        resumePC = 32'h2000; mipMTIP = 1'b1;
        #1 chk_st("t1_c0_idle", 4'b0000);
        step(); chk_st("t1_c1_drain", 4'b1100);
        step(); chk_st("t1_c2_trigger", 4'b1110);
        chk("t1_code", {28'd0, interruptCode}, 32'd7);
        chk("t1_retaddr", interruptRetAddr, 32'h2000);
        excptReq = 1'b1; csrWriteReq = 1'b1;
        #1 chk("t1_trig_grants_blocked", {30'd0, excptGrant, csrWriteGrant}, 32'd0);
        excptReq = 1'b0; csrWriteReq = 1'b0;
        mstatusMIE = 1'b0; mipMTIP = 1'b0;
        step(); chk_st("t1_c3_redirect", 4'b1101);
        chk("t1_code_held", {28'd0, interruptCode}, 32'd7);
        step(); chk_st("t1_c4_idle", 4'b0000);

        // Both pending: external wins; retaddr sampled at DRAIN->TRIGGER edge.
        mstatusMIE = 1'b1; mieMEIE = 1'b1; mipMTIP = 1'b1; mipMEIP = 1'b1;
        resumePC = 32'h1000;
        step(); chk_st("t2_drain", 4'b1100);
        step(); chk_st("t2_trigger", 4'b1110);
        resumePC = 32'h1234;
        chk("t2_code", {28'd0, interruptCode}, 32'd11);
        chk("t2_retaddr", interruptRetAddr, 32'h1000);
        mstatusMIE = 1'b0; mipMEIP = 1'b0;
        step(); chk_st("t2_redirect", 4'b1101);
        chk("t2_retaddr_held", interruptRetAddr, 32'h1000);
        chk("t2_code_held", {28'd0, interruptCode}, 32'd11);
        step(); chk_st("t2_idle", 4'b0000);

        // Exception in DRAIN aborts and outranks a concurrent CSR write.
        activeListEmpty = 1'b0; mstatusMIE = 1'b1;
        step(); chk_st("t3_drain", 4'b1100);
        excptReq = 1'b1; csrWriteReq = 1'b1;
        #1 chk("t3_grants_excpt_wins", {30'd0, excptGrant, csrWriteGrant}, 32'b10);
        step(); chk_st("t3_abort_idle", 4'b0000);
        excptReq = 1'b0; csrWriteReq = 1'b0;
        step(); chk_st("t3_redrain", 4'b1100);

        // CSR write in DRAIN clears MIE: granted, then the attempt aborts.
        csrWriteReq = 1'b1;
        #1 chk("t4_csr_grant", {30'd0, excptGrant, csrWriteGrant}, 32'b01);
        step(); chk_st("t4_still_drain", 4'b1100);
        csrWriteReq = 1'b0; mstatusMIE = 1'b0;
        step(); chk_st("t4_abort_idle", 4'b0000);

        // Exception and empty active list together: exception wins, then retry succeeds.
        mstatusMIE = 1'b1; activeListEmpty = 1'b1; resumePC = 32'h3000;
        step(); chk_st("t5_drain", 4'b1100);
        excptReq = 1'b1;
        #1 chk("t5_excpt_grant", {31'd0, excptGrant}, 32'd1);
        step(); chk_st("t5_abort_idle", 4'b0000);
        excptReq = 1'b0;
        step(); chk_st("t5_redrain", 4'b1100);
        step(); chk_st("t5_trigger", 4'b1110);
        chk("t5_retaddr", interruptRetAddr, 32'h3000);

        // Asynchronous reset during TRIGGER: outputs drop at once, no redirect.
        rst = 1'b1;
        #1 chk_st("t6_rst_status", 4'b0000);
        chk("t6_rst_code", {28'd0, interruptCode}, 32'd0);
        chk("t6_rst_retaddr", interruptRetAddr, 32'd0);
        mstatusMIE = 1'b0; mipMTIP = 1'b0;
        step();
        rst = 1'b0;
        step(); chk_st("t6_no_redirect", 4'b0000);

`ifdef RSD_INTERRUPT_DRAIN_TIMEOUT_EN
        // Drain timeout: 8 DRAIN cycles, 4 unstalled HOLDOFF cycles, IDLE, then DRAIN again.
        activeListEmpty = 1'b0; mstatusMIE = 1'b1; mipMTIP = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(); chk_st("t7_drain", 4'b1100);
        end
        for (int i = 0; i < 4; i++) begin
            step(); chk_st("t7_holdoff", 4'b1000);
        end
        step(); chk_st("t7_idle", 4'b0000);
        step(); chk_st("t7_redrain", 4'b1100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
